// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/instruction widths, opcode constants and
// the fetch FSM state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned CNT_W   = 16;

  localparam logic [INSTR_W-1:0] NOP_OP  = 16'h0000;
  localparam logic [INSTR_W-1:0] HALT_OP = 16'hFFFF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: DEPTH x INSTR_W array, synchronous write, combinational
// read with write-first bypass (a write to the address being read this cycle
// returns the write data).
// Ports:
//   clk    - rising-edge clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data (combinational)
module instr_mem #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned DEPTH   = 2 ** cpu_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    if (we && (waddr == raddr)) begin
      rdata = wdata;
    end else begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: reads the instruction memory at pc and registers
// instruction + PC into the IF/ID register. Supports stall, flush, sticky
// HALT detection and a saturating count of valid fetches.
// Ports:
//   clk         - rising-edge clock
//   rst         - synchronous active-high reset
//   pc          - fetch address
//   stall       - hold IF/ID contents
//   flush       - squash IF/ID contents (overrides stall)
//   prog_we     - program-load write enable
//   prog_addr   - program-load address
//   prog_data   - program-load data
//   instr       - IF/ID instruction
//   pc_out      - PC of instr
//   valid       - instr/pc_out hold a live fetch
//   halted      - HALT has been fetched (sticky until reset)
//   fetch_count - valid fetches since reset, saturating
module fetch_stage #(
  parameter int unsigned          ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned          INSTR_W = cpu_pkg::INSTR_W,
  parameter int unsigned          DEPTH   = 2 ** cpu_pkg::ADDR_W,
  parameter logic [INSTR_W-1:0]   NOP_OP  = cpu_pkg::NOP_OP,
  parameter logic [INSTR_W-1:0]   HALT_OP = cpu_pkg::HALT_OP,
  parameter int unsigned          CNT_W   = cpu_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               stall,
  input  logic               flush,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  import cpu_pkg::*;

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INSTR_W-1:0] mem_rdata;

  instr_mem #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      instr_q <= NOP_OP;
      pc_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          instr_d = NOP_OP;
          pc_d    = pc;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = mem_rdata;
          pc_d    = pc;
          valid_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (mem_rdata == HALT_OP) begin
            state_d = HALTED;
          end
        end
      end
      HALTED: begin
        // pc_out keeps the HALT's PC so a later unflushed cycle can
        // redisplay the HALT after a flush blanked it.
        if (flush) begin
          instr_d = NOP_OP;
          valid_d = 1'b0;
        end else begin
          instr_d = HALT_OP;
          valid_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign instr       = instr_q;
  assign pc_out      = pc_q;
  assign valid       = valid_q;
  assign halted      = (state_q == HALTED);
  assign fetch_count = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the 8-bit program counter.
- Each cycle it takes the PC value and reads a 256-entry instruction memory, which can be loaded at run time.
- It registers the instruction and its PC into the IF/ID pipeline register for the decode stage.
- It supports stall and flush, detects a HALT opcode, and counts retired fetches.

Parameters:
- ADDR_W, 8, PC/memory address width
- INSTR_W, 16, instruction width
- DEPTH, 256, memory entries (2**ADDR_W)
- NOP_OP, 16'h0000, bubble instruction driven when the output is invalid
- HALT_OP, 16'hFFFF, opcode that stops fetching
- CNT_W, 16, fetch counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous and active-high
- pc  in  ADDR_W  fetch address from program_counter
- stall  in  1  decode not ready; hold IF/ID contents
- flush  in  1  squash current IF/ID contents (branch/redirect)
- prog_we  in  1  program-load write enable
- prog_addr  in  ADDR_W  program-load address
- prog_data  in  INSTR_W  program-load data
- instr  out  INSTR_W  IF/ID instruction
- pc_out  out  ADDR_W  PC of instr
- valid  out  1  instr/pc_out hold a live fetch
- halted  out  1  HALT has been fetched; sticky
- fetch_count  out  CNT_W  number of valid fetches since reset; saturating

Behaviour:
- Reset (rst=1 at a clk edge): instr=NOP_OP, pc_out=0, valid=0, halted=0, fetch_count=0, FSM=RUN.
- Reset does not clear memory contents.
- Reset wins over every other input.
- Latency: the pc presented in cycle N appears on instr/pc_out after the edge ending cycle N (1 cycle).
  - The first valid output is one cycle after rst deasserts.
- Memory:
  - Combinational read mem[pc] feeds the IF/ID register.
  - Write on a clk edge when prog_we=1.
  - Same-cycle write and fetch to the same address: the fetched value is prog_data (write-first bypass).
- FSM states:
  - RUN:
    - Priority 1, flush=1: instr=NOP_OP, valid=0, pc_out=pc.
    - Priority 2, else stall=1: instr, pc_out and valid hold their values.
    - Priority 3, else: instr=mem[pc], pc_out=pc, valid=1, fetch_count+1.
    - If the loaded instruction equals HALT_OP, go to HALTED and set halted=1. The HALT itself is output with valid=1 and is counted.
  - HALTED:
    - Ignores pc and stall; memory writes still occur.
    - With flush=0: the HALT instruction stays displayed (instr=HALT_OP, pc_out=its PC, valid=1), so decode sees it.
    - With flush=1: valid=0, instr=NOP_OP.
    - halted stays 1; no new fetches; only rst exits.
- Flush overrides stall when both are 1. Flush never increments fetch_count.
- A HALT fetched while stall=1 is not loaded and does not halt; the check applies only to instructions actually loaded.
- fetch_count saturates at 2**CNT_W-1 and does not wrap.
- pc wrap 8'hFF->8'h00 needs no special handling; pc_out follows the input.
- Stall held indefinitely: outputs are stable, and the counter does not advance.

Decomposition:
- Shared package (cpu_pkg):
  - ADDR_W, INSTR_W
  - NOP_OP, HALT_OP opcode constants
  - fetch FSM state encoding (RUN=0, HALTED=1)
- Sub-module instr_mem: DEPTH x INSTR_W array, synchronous write, combinational read, write-first bypass.
- fetch_stage holds the IF/ID register, the FSM and the counter.

Test Plan:
- Reset/basic: load mem[0..3]=16'h1111,16'h2222,16'h3333,16'h4444, then release rst with pc incrementing 0..3 -> one cycle later instr=1111/pc_out=0/valid=1, then 2222, 3333, 4444 in order; fetch_count reaches 4.
- Stall: stall=1 for 3 cycles while pc advances 2..4 -> instr/pc_out frozen at the pre-stall value; fetch_count unchanged; resumes with mem[5] when stall drops.
- Flush priority: flush=1 and stall=1 in the same cycle -> next cycle valid=0, instr=16'h0000, no count increment; normal fetch the cycle after.
- Halt: mem[6]=16'hFFFF and pc reaches 6 -> output instr=FFFF/pc_out=6/valid=1, halted=1. Then, for 10 cycles as pc advances, outputs are unchanged and fetch_count is frozen. Then rst=1 -> all outputs reset and halted=0.
- Write-first: prog_we=1, prog_addr=8'h10, prog_data=16'hABCD in the same cycle as pc=8'h10 -> next cycle instr=ABCD.
- Saturation/wrap: run with CNT_W=4 over 20 fetches, with pc wrapping FF->00 -> fetch_count sticks at 15; pc_out shows 00 after FF.
